// File: rtl/voice_allocator_pkg.sv
// Shared constants and types for the polyphonic voice allocator.
//   MIDI_BYTES      : width of one packed MIDI event (status, data1, data2)
//   *_CH0           : channel-0 status bytes recognised by the allocator
//   CC_ALL_NOTES_OFF: controller number that releases every held voice
//   alloc_state_t   : allocator FSM states
package voice_allocator_pkg;

  localparam int MIDI_BYTES = 24;

  localparam logic [7:0] NOTE_ON_CH0      = 8'h90;
  localparam logic [7:0] NOTE_OFF_CH0     = 8'h80;
  localparam logic [7:0] CC_CH0           = 8'hB0;
  localparam logic [7:0] CC_ALL_NOTES_OFF = 8'h7B;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } alloc_state_t;

endpackage

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator.
// Accepts one channel-0 MIDI event per handshake, scans the voice slots one
// per cycle, then commits a NOTE_ON (retrigger > free > steal oldest),
// NOTE_OFF or all-notes-off update to the per-voice registers.
// Ports:
//   clk_in, rst_n_in   : clock, asynchronous active-low reset
//   midi_event         : [23:16] status, [15:8] data1, [7:0] data2
//   event_valid_in     : midi_event is valid
//   event_ready_out    : event can be accepted this cycle (IDLE only)
//   voice_note_out     : per-voice MIDI note
//   voice_vel_out      : per-voice velocity
//   voice_gate_out     : per-voice key-held flag
//   voice_trig_out     : per-voice one-cycle (re)allocation pulse
//   steal_out          : one-cycle pulse when a held voice was stolen
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int AGE_BITS   = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic [MIDI_BYTES-1:0]         midi_event,
  input  logic                          event_valid_in,
  output logic                          event_ready_out,
  output logic [NUM_VOICES-1:0][7:0]    voice_note_out,
  output logic [NUM_VOICES-1:0][6:0]    voice_vel_out,
  output logic [NUM_VOICES-1:0]         voice_gate_out,
  output logic [NUM_VOICES-1:0]         voice_trig_out,
  output logic                          steal_out
);

  localparam int IDXW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_VOICES - 1);

  // Saturating age increment: a voice that is held forever stays "oldest"
  // instead of wrapping back to young.
  function automatic logic [AGE_BITS-1:0] age_inc(input logic [AGE_BITS-1:0] a);
    return (a == {AGE_BITS{1'b1}}) ? a : a + 1'b1;
  endfunction

  alloc_state_t            r_state;
  logic                    r_ready;
  logic [MIDI_BYTES-1:0]   r_event;
  logic [IDXW-1:0]         r_idx;

  logic [7:0]              r_note [NUM_VOICES];
  logic [6:0]              r_vel  [NUM_VOICES];
  logic [AGE_BITS-1:0]     r_age  [NUM_VOICES];
  logic [NUM_VOICES-1:0]   r_gate;
  logic [NUM_VOICES-1:0]   r_trig;
  logic                    r_steal;

  // Scan results
  logic                    r_match_found;
  logic [IDXW-1:0]         r_match_idx;
  logic                    r_free_found;
  logic [IDXW-1:0]         r_free_idx;
  logic                    r_old_found;
  logic [IDXW-1:0]         r_old_idx;
  logic [AGE_BITS-1:0]     r_old_age;

  logic [7:0]              w_status;
  logic [7:0]              w_data1;
  logic [7:0]              w_data2;
  logic                    w_is_on;
  logic                    w_is_off;
  logic                    w_is_all_off;
  logic                    w_cur_gate;
  logic [7:0]              w_cur_note;
  logic [AGE_BITS-1:0]     w_cur_age;
  logic [IDXW-1:0]         w_tgt_idx;
  logic                    w_steal;

  assign w_status = r_event[23:16];
  assign w_data1  = r_event[15:8];
  assign w_data2  = r_event[7:0];

  // A NOTE_ON with zero velocity is the running-status form of NOTE_OFF.
  assign w_is_on      = (w_status == NOTE_ON_CH0) && (w_data2 != 8'h00);
  assign w_is_off     = (w_status == NOTE_OFF_CH0) ||
                        ((w_status == NOTE_ON_CH0) && (w_data2 == 8'h00));
  assign w_is_all_off = (w_status == CC_CH0) && (w_data1 == CC_ALL_NOTES_OFF);

  assign w_cur_gate = r_gate[r_idx];
  assign w_cur_note = r_note[r_idx];
  assign w_cur_age  = r_age[r_idx];

  // Target priority: retrigger the held note, else a free slot, else steal.
  always_comb begin
    w_tgt_idx = r_old_idx;
    w_steal   = 1'b0;
    if (r_match_found) begin
      w_tgt_idx = r_match_idx;
    end else if (r_free_found) begin
      w_tgt_idx = r_free_idx;
    end else begin
      w_steal = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state       <= IDLE;
      r_ready       <= 1'b1;
      r_event       <= '0;
      r_idx         <= '0;
      r_gate        <= '0;
      r_trig        <= '0;
      r_steal       <= 1'b0;
      r_match_found <= 1'b0;
      r_match_idx   <= '0;
      r_free_found  <= 1'b0;
      r_free_idx    <= '0;
      r_old_found   <= 1'b0;
      r_old_idx     <= '0;
      r_old_age     <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_note[v] <= '0;
        r_vel[v]  <= '0;
        r_age[v]  <= '0;
      end
    end else begin
      r_trig  <= '0;
      r_steal <= 1'b0;
      case (r_state)
        IDLE: begin
          if (event_valid_in && r_ready) begin
            r_event       <= midi_event;
            r_idx         <= '0;
            r_match_found <= 1'b0;
            r_free_found  <= 1'b0;
            r_old_found   <= 1'b0;
            r_ready       <= 1'b0;
            r_state       <= SCAN;
          end
        end

        SCAN: begin
          if (w_cur_gate && (w_cur_note == w_data1) && !r_match_found) begin
            r_match_found <= 1'b1;
            r_match_idx   <= r_idx;
          end
          if (!w_cur_gate && !r_free_found) begin
            r_free_found <= 1'b1;
            r_free_idx   <= r_idx;
          end
          // Strict '>' keeps the lowest index on equal ages.
          if (w_cur_gate && (!r_old_found || (w_cur_age > r_old_age))) begin
            r_old_found <= 1'b1;
            r_old_idx   <= r_idx;
            r_old_age   <= w_cur_age;
          end
          if (r_idx == LAST_IDX) begin
            r_state <= COMMIT;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        COMMIT: begin
          if (w_is_on) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (v == int'(w_tgt_idx)) begin
                r_note[v] <= w_data1;
                r_vel[v]  <= w_data2[6:0];
                r_age[v]  <= '0;
                r_gate[v] <= 1'b1;
                r_trig[v] <= 1'b1;
              end else if (r_gate[v]) begin
                r_age[v] <= age_inc(r_age[v]);
              end
            end
            r_steal <= w_steal;
          end else if (w_is_off) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (r_gate[v] && (r_note[v] == w_data1)) begin
                r_gate[v] <= 1'b0;
              end
            end
          end else if (w_is_all_off) begin
            r_gate <= '0;
          end
          r_ready <= 1'b1;
          r_state <= IDLE;
        end

        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign event_ready_out = r_ready;
  assign voice_gate_out  = r_gate;
  assign voice_trig_out  = r_trig;
  assign steal_out       = r_steal;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
    assign voice_note_out[g] = r_note[g];
    assign voice_vel_out[g]  = r_vel[g];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator with NUM_VOICES=4.
module tb_voice_allocator;

  localparam int NV = 4;

  logic               clk_in;
  logic               rst_n_in;
  logic [23:0]        midi_event;
  logic               event_valid_in;
  logic               event_ready_out;
  logic [NV-1:0][7:0] voice_note_out;
  logic [NV-1:0][6:0] voice_vel_out;
  logic [NV-1:0]      voice_gate_out;
  logic [NV-1:0]      voice_trig_out;
  logic               steal_out;

  int n_checks;
  int n_fail;

  voice_allocator #(.NUM_VOICES(NV), .AGE_BITS(8)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .midi_event      (midi_event),
    .event_valid_in  (event_valid_in),
    .event_ready_out (event_ready_out),
    .voice_note_out  (voice_note_out),
    .voice_vel_out   (voice_vel_out),
    .voice_gate_out  (voice_gate_out),
    .voice_trig_out  (voice_trig_out),
    .steal_out       (steal_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Presents one event and returns #1 after its accept edge.
  task automatic send_event(input logic [23:0] ev);
    int n;
    n = 0;
    while (!event_ready_out && n < 50) begin
      @(posedge clk_in); #1;
      n++;
    end
    n_checks++;
    if (!event_ready_out) begin
      n_fail++;
      $display("FAIL send_ready_timeout ev=%h ready=%b required=1", ev, event_ready_out);
    end
    midi_event     = ev;
    event_valid_in = 1'b1;
    @(posedge clk_in); #1;
    event_valid_in = 1'b0;
  endtask

  // Sends an event and returns #1 after the commit edge (outputs visible).
  task automatic run_event(input logic [23:0] ev);
    send_event(ev);
    repeat (NV + 1) begin
      @(posedge clk_in); #1;
    end
  endtask

  task automatic test_reset;
    rst_n_in = 1'b0;
    event_valid_in = 1'b0;
    midi_event = '0;
    repeat (3) @(posedge clk_in);
    #1;
    n_checks++;
    if ({event_ready_out, voice_gate_out, voice_trig_out, steal_out} !== {1'b1, 4'h0, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_ctrl got rdy=%b gate=%b trig=%b steal=%b required 1/0000/0000/0",
               event_ready_out, voice_gate_out, voice_trig_out, steal_out);
    end
    n_checks++;
    if ({voice_note_out, voice_vel_out} !== 60'h0) begin
      n_fail++;
      $display("FAIL reset_data note=%h vel=%h required 0", voice_note_out, voice_vel_out);
    end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
  endtask

  task automatic test_fill;
    logic [23:0] evs [4];
    evs[0] = 24'h903C64; evs[1] = 24'h904050; evs[2] = 24'h904340; evs[3] = 24'h904830;
    for (int i = 0; i < 4; i++) begin
      send_event(evs[i]);
      repeat (NV) begin
        @(posedge clk_in); #1;
      end
      n_checks++;
      if (voice_trig_out !== 4'b0000 || event_ready_out !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_early%0d trig=%b rdy=%b required 0000/0", i, voice_trig_out, event_ready_out);
      end
      @(posedge clk_in); #1;
      n_checks++;
      if (voice_trig_out !== (4'b0001 << i) || steal_out !== 1'b0 || event_ready_out !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_trig%0d trig=%b steal=%b rdy=%b required %b/0/1",
                 i, voice_trig_out, steal_out, event_ready_out, 4'b0001 << i);
      end
      @(posedge clk_in); #1;
      n_checks++;
      if (voice_trig_out !== 4'b0000) begin
        n_fail++;
        $display("FAIL fill_trig_off%0d trig=%b required 0000", i, voice_trig_out);
      end
    end
    n_checks++;
    if (voice_note_out !== 32'h48_43_40_3C || voice_gate_out !== 4'b1111) begin
      n_fail++;
      $display("FAIL fill_notes note=%h gate=%b required 4843403c/1111", voice_note_out, voice_gate_out);
    end
    n_checks++;
    if (voice_vel_out !== {7'h30, 7'h40, 7'h50, 7'h64}) begin
      n_fail++;
      $display("FAIL fill_vel vel=%h required %h", voice_vel_out, {7'h30, 7'h40, 7'h50, 7'h64});
    end
  endtask

  task automatic test_steal;
    run_event(24'h904C7F);
    n_checks++;
    if (voice_trig_out !== 4'b0001 || steal_out !== 1'b1) begin
      n_fail++;
      $display("FAIL steal_pulse trig=%b steal=%b required 0001/1", voice_trig_out, steal_out);
    end
    n_checks++;
    if (voice_note_out !== 32'h48_43_40_4C || voice_vel_out !== {7'h30, 7'h40, 7'h50, 7'h7F}) begin
      n_fail++;
      $display("FAIL steal_data note=%h vel=%h required 4843404c/%h",
               voice_note_out, voice_vel_out, {7'h30, 7'h40, 7'h50, 7'h7F});
    end
    @(posedge clk_in); #1;
    n_checks++;
    if (voice_trig_out !== 4'b0000 || steal_out !== 1'b0) begin
      n_fail++;
      $display("FAIL steal_one_cycle trig=%b steal=%b required 0000/0", voice_trig_out, steal_out);
    end
  endtask

  task automatic test_retrigger_off;
    run_event(24'h904020);
    n_checks++;
    if (voice_trig_out !== 4'b0010 || steal_out !== 1'b0 ||
        voice_vel_out !== {7'h30, 7'h40, 7'h20, 7'h7F}) begin
      n_fail++;
      $display("FAIL retrig trig=%b steal=%b vel=%h required 0010/0/%h",
               voice_trig_out, steal_out, voice_vel_out, {7'h30, 7'h40, 7'h20, 7'h7F});
    end
    run_event(24'h804000);
    n_checks++;
    if (voice_gate_out !== 4'b1101 || voice_note_out !== 32'h48_43_40_4C || voice_trig_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL note_off gate=%b note=%h trig=%b required 1101/4843404c/0000",
               voice_gate_out, voice_note_out, voice_trig_out);
    end
    // Voice 1 is free; the oldest held voice (2) must not be stolen.
    run_event(24'h903010);
    n_checks++;
    if (voice_trig_out !== 4'b0010 || steal_out !== 1'b0 || voice_gate_out !== 4'b1111 ||
        voice_note_out !== 32'h48_43_30_4C) begin
      n_fail++;
      $display("FAIL free_reuse trig=%b steal=%b gate=%b note=%h required 0010/0/1111/4843304c",
               voice_trig_out, steal_out, voice_gate_out, voice_note_out);
    end
  endtask

  task automatic test_off_variants;
    run_event(24'h904300);
    n_checks++;
    if (voice_gate_out !== 4'b1011 || voice_trig_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL vel0_off gate=%b trig=%b required 1011/0000", voice_gate_out, voice_trig_out);
    end
    run_event(24'hB07B00);
    n_checks++;
    if (voice_gate_out !== 4'b0000 || voice_note_out !== 32'h48_43_30_4C) begin
      n_fail++;
      $display("FAIL all_off gate=%b note=%h required 0000/4843304c", voice_gate_out, voice_note_out);
    end
    run_event(24'hE00040);
    n_checks++;
    if (voice_gate_out !== 4'b0000 || voice_note_out !== 32'h48_43_30_4C || voice_trig_out !== 4'b0000 ||
        steal_out !== 1'b0 || voice_vel_out !== {7'h30, 7'h40, 7'h10, 7'h7F}) begin
      n_fail++;
      $display("FAIL other_status gate=%b note=%h vel=%h trig=%b steal=%b required unchanged",
               voice_gate_out, voice_note_out, voice_vel_out, voice_trig_out, steal_out);
    end
  endtask

  task automatic test_back_to_back;
    logic [23:0] q [5];
    int k, lowcnt, cyc;
    q[0] = 24'h905011; q[1] = 24'h905122; q[2] = 24'h905233; q[3] = 24'h805000; q[4] = 24'h905344;
    k = 0; lowcnt = 0; cyc = 0;
    midi_event = q[0];
    event_valid_in = 1'b1;
    while (k < 5 && cyc < 200) begin
      @(negedge clk_in);
      if (event_ready_out) begin
        if (k > 0) begin
          n_checks++;
          if (lowcnt != 5) begin
            n_fail++;
            $display("FAIL b2b_gap%0d ready_low=%0d required 5", k, lowcnt);
          end
        end
        @(posedge clk_in); #1;
        k++;
        if (k < 5) midi_event = q[k];
        else event_valid_in = 1'b0;
        lowcnt = 0;
      end else begin
        lowcnt++;
      end
      cyc++;
    end
    event_valid_in = 1'b0;
    n_checks++;
    if (k != 5) begin
      n_fail++;
      $display("FAIL b2b_timeout accepted=%0d required 5", k);
    end
    repeat (NV + 1) begin
      @(posedge clk_in); #1;
    end
    n_checks++;
    if (voice_note_out !== 32'h48_52_51_53 || voice_gate_out !== 4'b0111 ||
        voice_vel_out !== {7'h30, 7'h33, 7'h22, 7'h44}) begin
      n_fail++;
      $display("FAIL b2b_final note=%h vel=%h gate=%b required 48525153/%h/0111",
               voice_note_out, voice_vel_out, voice_gate_out, {7'h30, 7'h33, 7'h22, 7'h44});
    end
    repeat (3) @(posedge clk_in);
    #1;
    n_checks++;
    if (event_ready_out !== 1'b1 || voice_note_out !== 32'h48_52_51_53 || voice_trig_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL b2b_idle rdy=%b note=%h trig=%b required 1/48525153/0000",
               event_ready_out, voice_note_out, voice_trig_out);
    end
  endtask

  task automatic test_reset_mid_scan;
    logic seen;
    send_event(24'h903C64);
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    rst_n_in = 1'b0;
    #1;
    n_checks++;
    if (event_ready_out !== 1'b1 || voice_gate_out !== 4'h0 || {voice_note_out, voice_vel_out} !== 60'h0) begin
      n_fail++;
      $display("FAIL rst_mid_scan rdy=%b gate=%b note=%h vel=%h required 1/0/0/0",
               event_ready_out, voice_gate_out, voice_note_out, voice_vel_out);
    end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk_in); #1;
      if (voice_trig_out !== 4'h0 || steal_out !== 1'b0 || voice_gate_out !== 4'h0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0 || event_ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_no_trig activity=%b rdy=%b required 0/1", seen, event_ready_out);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n_in = 1'b1;
    event_valid_in = 1'b0;
    midi_event = '0;
    test_reset();
    test_fill();
    test_steal();
    test_retrigger_off();
    test_off_variants();
    test_back_to_back();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
